// File: rtl/j1_uart_io.sv
// j1 IO-space UART peripheral: 8N1 transmitter and receiver, each behind a small FIFO.
// Data register at +0 (write pushes TX, read pops RX), status/clear register at +4.
module j1_uart_io #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [15:0] BASE_ADDR    = 16'h1000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [15:0]      io_addr,
    input  logic [WIDTH-1:0] io_wdata,
    output logic [WIDTH-1:0] io_rdata,
    input  logic             uart_rxd,
    output logic             uart_txd
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    // ---------------- address decode and strobes ----------------
    logic hit, sel_data, sel_stat;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic clr_ovr, clr_ferr;

    assign hit      = (io_addr[15:3] == BASE_ADDR[15:3]);
    assign sel_data = hit && !io_addr[2];
    assign sel_stat = hit &&  io_addr[2];
    assign clr_ovr  = io_wr && sel_stat && io_wdata[3];
    assign clr_ferr = io_wr && sel_stat && io_wdata[4];

    logic unused_bits;
    assign unused_bits = &{1'b0, io_addr[1:0], io_wdata[WIDTH-1:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp;
    logic        tx_empty, tx_full;
    logic [7:0]  tx_head;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW-1:0] == tx_rp[AW-1:0]) && (tx_wp[AW] != tx_rp[AW]);
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign tx_push  = io_wr && sel_data && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (!resetq) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= io_wdata[7:0];
    end

    // ---------------- TX FSM ----------------
    tx_state_t       tx_state, tx_state_n;
    logic [BW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic            tx_tick;

    assign tx_tick = (tx_cnt == '0);

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                if (tx_tick && tx_bit == 3'd7) tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else begin
            tx_state <= tx_state_n;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_cnt   <= BIT_LAST;
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= BIT_LAST;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= {1'b1, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        uart_txd = 1'b1;
        case (tx_state)
            TX_START: uart_txd = 1'b0;
            TX_DATA:  uart_txd = tx_shift[0];
            default:  uart_txd = 1'b1;
        endcase
    end

    // ---------------- RX synchronizer ----------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t       rx_state, rx_state_n;
    logic [BW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_tick, rx_done, ferr_set;

    assign rx_tick = (rx_cnt == '0);

    always_comb begin
        rx_state_n = rx_state;
        rx_done    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_tick) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_tick && rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_sync) begin
                        rx_done    = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        rx_state_n = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_sync) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // The half-bit count is held while idle so the start state begins aligned to mid-bit.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= HALF_LAST;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= HALF_LAST;
            end else if (rx_tick) begin
                rx_cnt <= BIT_LAST;
            end else begin
                rx_cnt <= rx_cnt - 1'b1;
            end
            if (rx_state == RX_IDLE) begin
                rx_bit <= '0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp, rx_rp;
    logic        rx_empty, rx_full;
    logic [7:0]  rx_head;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW-1:0] == rx_rp[AW-1:0]) && (rx_wp[AW] != rx_rp[AW]);
    assign rx_head  = rx_mem[rx_rp[AW-1:0]];
    assign rx_pop   = io_rd && sel_data && !rx_empty;
    assign rx_push  = rx_done && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (!resetq) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
    end

    // ---------------- sticky flags ----------------
    logic ovr, ferr;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (rx_done && rx_full && !rx_pop) ovr <= 1'b1;
            else if (clr_ovr)                  ovr <= 1'b0;
            if (ferr_set)      ferr <= 1'b1;
            else if (clr_ferr) ferr <= 1'b0;
        end
    end

    // ---------------- read mux ----------------
    logic [4:0] status;
    assign status = {ferr, ovr, (tx_empty && tx_state == TX_IDLE), tx_full, !rx_empty};

    always_comb begin
        io_rdata = '0;
        if (sel_data && !rx_empty) io_rdata = WIDTH'(rx_head);
        else if (sel_stat)         io_rdata = WIDTH'(status);
    end

endmodule

// File: tb/tb_j1_uart_io.sv
// Randomized self-checking bench for j1_uart_io with a small UART, tiny FIFOs.
// Expected values come from queue-based models of the FIFOs and the 8N1 frame format.
module tb_j1_uart_io;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] DATA_A = 16'h1000;
    localparam logic [15:0] STAT_A = 16'h1004;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    j1_uart_io #(
        .WIDTH(32),
        .BASE_ADDR(16'h1000),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .resetq(resetq),
        .io_rd(io_rd),
        .io_wr(io_wr),
        .io_addr(io_addr),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // reference model state
    logic [7:0] rx_q[$];
    logic       ovr_m  = 1'b0;
    logic       ferr_m = 1'b0;

    // frames decoded from uart_txd: byte and first start-bit cycle
    logic [7:0] mon_bytes[$];
    int         mon_starts[$];

    initial begin : tx_monitor
        int         st;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0 && resetq === 1'b1) begin
                st = cycle;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                if (uart_txd === 1'b1) begin
                    mon_bytes.push_back(b);
                    mon_starts.push_back(st);
                end
            end
        end
    end

    function automatic logic [31:0] exp_status(input logic tx_idle, input logic tx_full);
        return {27'd0, ferr_m, ovr_m, tx_idle, tx_full, (rx_q.size() != 0)};
    endfunction

    // all bus tasks start and end just after a falling edge
    task automatic io_write(input logic [15:0] a, input logic [31:0] d);
        io_addr = a; io_wdata = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [31:0] d);
        io_addr = a; io_rd = 1'b1;
        #1 d = io_rdata;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        if (!stop) ferr_m = 1'b1;
        else if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else ovr_m = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        resetq = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
        resetq = 1'b1;
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL reset_status got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        io_read(DATA_A, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", d); end
    endtask

    task automatic test_tx_single;
        logic [7:0]  b;
        logic        e;
        logic [31:0] d;
        b = 8'hA5;
        mon_bytes.delete(); mon_starts.delete();
        io_write(DATA_A, 32'h0000_00A5);
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL tx_first_cycle got %b exp 1", uart_txd); end
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (k < CPB) e = 1'b0;
            else if (k < 9 * CPB) e = b[(k - CPB) / CPB];
            else e = 1'b1;
            checks++;
            if (uart_txd !== e) begin errors++; $display("FAIL tx_wave k=%0d got %b exp %b", k, uart_txd, e); end
        end
        repeat (3) @(negedge clk);
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL tx_done_status got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        checks++;
        if (mon_bytes.size() != 1 || mon_bytes[0] !== b) begin
            errors++; $display("FAIL tx_frame_byte got n=%0d exp A5", mon_bytes.size());
        end
    endtask

    task automatic test_rx_basic;
        logic [7:0]  b;
        logic [7:0]  e;
        logic [31:0] d;
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'h3C : 8'($urandom);
            send_frame(b, 1'b1);
            repeat (4) @(negedge clk);
            io_read(STAT_A, d);
            checks++;
            if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL rx_status_avail got %h exp %h", d, exp_status(1'b1, 1'b0)); end
            io_addr = DATA_A;
            #1;
            checks++;
            if (io_rdata !== {24'd0, rx_q[0]}) begin errors++; $display("FAIL rx_peek got %h exp %h", io_rdata, rx_q[0]); end
            @(negedge clk);
            io_read(DATA_A, d);
            e = rx_q.pop_front();
            checks++;
            if (d !== {24'd0, e}) begin errors++; $display("FAIL rx_data got %h exp %h", d, e); end
            io_read(STAT_A, d);
            checks++;
            if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL rx_status_empty got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        end
    endtask

    task automatic test_tx_back_to_back;
        logic [7:0]  exp_q[$];
        int          qlen;
        logic [31:0] d;
        mon_bytes.delete(); mon_starts.delete();
        io_write(DATA_A, 32'hF0);
        exp_q.push_back(8'hF0);
        repeat (3) @(negedge clk);
        // the first frame outlasts the burst below, so nothing leaves the FIFO meanwhile
        qlen = 0;
        for (int i = 1; i <= 5; i++) begin
            io_write(DATA_A, 32'(i));
            if (qlen < DEPTH) begin qlen++; exp_q.push_back(8'(i)); end
            io_read(STAT_A, d);
            checks++;
            if (d !== exp_status(1'b0, qlen == DEPTH)) begin
                errors++; $display("FAIL tx_full_status i=%0d got %h exp %h", i, d, exp_status(1'b0, qlen == DEPTH));
            end
        end
        repeat (6 * 10 * CPB) @(negedge clk);
        checks++;
        if (mon_bytes.size() != exp_q.size()) begin
            errors++; $display("FAIL tx_frame_count got %0d exp %0d", mon_bytes.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (mon_bytes[i] !== exp_q[i]) begin errors++; $display("FAIL tx_frame_data i=%0d got %h exp %h", i, mon_bytes[i], exp_q[i]); end
                if (i > 0) begin
                    checks++;
                    if (mon_starts[i] - mon_starts[i-1] != 10 * CPB) begin
                        errors++; $display("FAIL tx_gap i=%0d got %0d exp %0d", i, mon_starts[i] - mon_starts[i-1], 10 * CPB);
                    end
                end
            end
        end
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL tx_b2b_idle got %h exp %h", d, exp_status(1'b1, 1'b0)); end
    endtask

    task automatic test_rx_overrun;
        logic [7:0]  e;
        logic [31:0] d;
        for (int n = 0; n < 5; n++) send_frame(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0) || d !== 32'h0D) begin errors++; $display("FAIL ovr_status got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        io_write(STAT_A, 32'h8);
        ovr_m = 1'b0;
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL ovr_clear got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        for (int n = 0; n < DEPTH + 1; n++) begin
            io_read(DATA_A, d);
            e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
            checks++;
            if (d !== {24'd0, e}) begin errors++; $display("FAIL ovr_data n=%0d got %h exp %h", n, d, e); end
        end
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL ovr_drained got %h exp %h", d, exp_status(1'b1, 1'b0)); end
    endtask

    task automatic test_rx_errors;
        logic [31:0] d;
        send_frame(8'($urandom), 1'b0);
        repeat (6) @(negedge clk);
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0) || d !== 32'h14) begin errors++; $display("FAIL ferr_status got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (12) @(negedge clk);
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL glitch_status got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        io_read(DATA_A, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL glitch_data got %h exp 0", d); end
        io_write(STAT_A, 32'h10);
        ferr_m = 1'b0;
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL ferr_clear got %h exp %h", d, exp_status(1'b1, 1'b0)); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        int          bad;
        send_frame(8'($urandom), 1'b1);
        io_write(DATA_A, 32'($urandom));
        io_write(DATA_A, 32'($urandom));
        repeat (10) @(negedge clk);
        uart_rxd = 1'b0;
        repeat (6) @(negedge clk);
        resetq = 1'b0;
        uart_rxd = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL midreset_txd got %b exp 1", uart_txd); end
        resetq = 1'b1;
        rx_q.delete(); ovr_m = 1'b0; ferr_m = 1'b0;
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL midreset_status got %h exp %h", d, exp_status(1'b1, 1'b0)); end
        for (int n = 0; n < 2; n++) begin
            io_read(DATA_A, d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL midreset_data n=%0d got %h exp 0", n, d); end
        end
        io_read(16'h2000, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h exp 0", d); end
        io_read(16'h1008, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL adjacent_read got %h exp 0", d); end
        io_write(16'h0000, 32'h55);
        io_write(16'h1008, 32'h55);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL unmapped_write_txd got %0d low cycles exp 0", bad); end
        io_read(STAT_A, d);
        checks++;
        if (d !== exp_status(1'b1, 1'b0)) begin errors++; $display("FAIL final_status got %h exp %h", d, exp_status(1'b1, 1'b0)); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tx_single();
        test_rx_basic();
        test_tx_back_to_back();
        test_rx_overrun();
        test_rx_errors();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
